// File: rtl/tristate_bus_reader.sv
// Reader for a shared tri-state register bus: selects one source by index via
// its active-low chip select, waits a programmable number of Tick-qualified
// cycles for the bus to settle, samples the bus and returns the word through
// a valid/ready response handshake. Out-of-range indices answer immediately
// with an all-ones word and the error flag, without touching any chip select.
module tristate_bus_reader #(
  parameter int NrOfBits     = 8,
  parameter int NrOfSources  = 4,
  parameter int IndexBits    = 2,
  parameter int SettleCycles = 1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Tick,
  input  logic                   ReqValid,
  input  logic [IndexBits-1:0]   ReqIndex,
  output logic                   ReqReady,
  output logic [NrOfSources-1:0] CsN,
  input  logic [NrOfBits-1:0]    BusIn,
  output logic                   RspValid,
  output logic [NrOfBits-1:0]    RspData,
  output logic                   RspErr,
  input  logic                   RspReady
);

  // A settle time of zero would mean capturing before the source drives,
  // so it is promoted to one cycle.
  localparam int EffSettle = (SettleCycles < 1) ? 1 : SettleCycles;
  // The counter only ever reaches EffSettle-1, so clog2 bits never wrap.
  localparam int CntBits = (EffSettle > 1) ? $clog2(EffSettle) : 1;
  localparam logic [CntBits-1:0] CntLast = CntBits'(EffSettle - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CntBits-1:0]     cnt_q, cnt_d;
  logic [NrOfSources-1:0] csn_q, csn_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [NrOfBits-1:0]    rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;

  logic                   index_ok;
  logic [NrOfSources-1:0] sel_csn;

  // Range check of the requested index and its one-cold chip-select pattern
  always_comb begin
    index_ok = (int'(ReqIndex) < NrOfSources);
    sel_csn  = '1;
    for (int i = 0; i < NrOfSources; i++) begin
      if (int'(ReqIndex) == i) begin
        sel_csn[i] = 1'b0;
      end
    end
  end

  // State and datapath registers; reset releases every chip select at once
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      csn_q       <= '1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      csn_q       <= csn_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state and datapath updates: accept, settle/capture, consume
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    csn_d       = csn_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (Tick && ReqValid) begin
          if (index_ok) begin
            state_d = SELECT;
            cnt_d   = '0;
            csn_d   = sel_csn;
          end else begin
            // Nothing to select: answer straight away with the error word.
            state_d     = RESPOND;
            rsp_data_d  = '1;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
          end
        end
      end

      SELECT: begin
        if (Tick) begin
          if (cnt_q == CntLast) begin
            state_d     = RESPOND;
            rsp_data_d  = BusIn;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
            csn_d       = '1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      RESPOND: begin
        // Consumption is not gated by Tick so a fast consumer is never stalled.
        if (RspReady) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        csn_d   = '1;
      end
    endcase
  end

  // Outputs: ready is purely a function of state, the rest come from flops
  always_comb begin
    ReqReady = (state_q == IDLE);
    CsN      = csn_q;
    RspValid = rsp_valid_q;
    RspData  = rsp_data_q;
    RspErr   = rsp_err_q;
  end

endmodule

// File: tb/tb_tristate_bus_reader.sv
// Bench for tristate_bus_reader: three instances with settle times 1, 3 and 4
// share clock and reset; each has its own bus model where a source drives the
// bus only while its chip select is low.
module tb_tristate_bus_reader;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic       Reset;
  logic       tick      [3];
  logic       req_valid [3];
  logic [2:0] req_index [3];
  logic       req_ready [3];
  logic [3:0] csn       [3];
  logic [7:0] bus_in    [3];
  logic       rsp_valid [3];
  logic [7:0] rsp_data  [3];
  logic       rsp_err   [3];
  logic       rsp_ready [3];
  logic [7:0] src_val   [3][4];

  int settle_of [3] = '{1, 3, 4};

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int         d;
    logic [2:0] idx;
    logic [7:0] word;
    bit         alt;
    int         chg;
    logic [7:0] new_word;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;
  vec_t vecs [9];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      // Bus model: a source drives only while selected, otherwise pulled low
      always_comb begin
        bus_in[gi] = 8'h00;
        for (int i = 0; i < 4; i++) begin
          if (!csn[gi][i]) bus_in[gi] = src_val[gi][i];
        end
      end

      tristate_bus_reader #(
        .NrOfBits    (8),
        .NrOfSources (4),
        .IndexBits   (3),
        .SettleCycles((gi == 0) ? 1 : ((gi == 1) ? 3 : 4))
      ) u_dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Tick    (tick[gi]),
        .ReqValid(req_valid[gi]),
        .ReqIndex(req_index[gi]),
        .ReqReady(req_ready[gi]),
        .CsN     (csn[gi]),
        .BusIn   (bus_in[gi]),
        .RspValid(rsp_valid[gi]),
        .RspData (rsp_data[gi]),
        .RspErr  (rsp_err[gi]),
        .RspReady(rsp_ready[gi])
      );
    end
  endgenerate

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One complete read on instance d, with optional Tick gating, a bus change
  // after chg Tick edges, and hold cycles of backpressure before consuming.
  task automatic do_read(input int d, input logic [2:0] idx, input logic [7:0] word,
                         input bit alt, input int chg, input logic [7:0] new_word,
                         input logic [7:0] exp_data, input logic exp_err,
                         input int hold, input logic [2:0] hold_idx);
    exp_t       e;
    logic [3:0] one;
    logic [3:0] exp_csn;
    int         edges;
    int         low;
    int         guard;
    bit         t;
    one     = 4'b0001;
    exp_csn = (idx < 3'd4) ? ~(one << idx) : 4'hF;

    @(negedge Clock);
    if (idx < 3'd4) src_val[d][idx] = word;
    req_index[d] = idx;
    req_valid[d] = 1'b1;
    tick[d]      = 1'b1;
    e.data = exp_data;
    e.err  = exp_err;
    sb_q.push_back(e);

    @(posedge Clock); #1;
    check("accept", 32'(req_ready[d]), 32'd0);
    req_valid[d] = 1'b0;

    edges = 0;
    low   = 0;
    guard = 0;
    while (!rsp_valid[d] && guard < 100) begin
      check("csn_select", 32'(csn[d]), 32'(exp_csn));
      if (csn[d] != 4'hF) low++;
      @(negedge Clock);
      t = alt ? ~tick[d] : 1'b1;
      tick[d] = t;
      @(posedge Clock); #1;
      if (t) begin
        edges++;
        if (edges == chg) src_val[d][idx] = new_word;
      end
      guard++;
    end

    if (guard >= 100) begin
      tests++;
      failed++;
      $display("FAIL rsp_timeout: inst %0d idx %0d no RspValid within 100 cycles", d, idx);
      void'(sb_q.pop_front());
    end else begin
      check("settle_edges", 32'(edges), (idx < 3'd4) ? 32'(settle_of[d]) : 32'd0);
      check("csn_low_cycles", 32'(low),
            (idx < 3'd4) ? (alt ? 32'(2 * settle_of[d]) : 32'(settle_of[d])) : 32'd0);
      check("csn_release", 32'(csn[d]), 32'hF);
      e = sb_q.pop_front();
      check("rsp_data", 32'(rsp_data[d]), 32'(e.data));
      check("rsp_err", 32'(rsp_err[d]), 32'(e.err));
      $display("[TB] inst %0d read idx %0d -> data %02h err %0d (expected %02h/%0d) after %0d tick edges",
               d, idx, rsp_data[d], rsp_err[d], e.data, e.err, edges);

      for (int k = 0; k < hold; k++) begin
        @(negedge Clock);
        req_valid[d] = 1'b1;
        req_index[d] = hold_idx;
        tick[d]      = 1'b1;
        @(posedge Clock); #1;
        check("hold_valid", 32'(rsp_valid[d]), 32'd1);
        check("hold_data", 32'(rsp_data[d]), 32'(e.data));
        check("hold_err", 32'(rsp_err[d]), 32'(e.err));
        check("hold_req_ready", 32'(req_ready[d]), 32'd0);
        check("hold_csn", 32'(csn[d]), 32'hF);
      end

      @(negedge Clock);
      rsp_ready[d] = 1'b1;
      @(posedge Clock); #1;
      rsp_ready[d] = 1'b0;
      check("consume_valid", 32'(rsp_valid[d]), 32'd0);
      check("consume_req_ready", 32'(req_ready[d]), 32'd1);
      check("consume_data_held", 32'(rsp_data[d]), 32'(e.data));
      check("consume_err_held", 32'(rsp_err[d]), 32'(e.err));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            d  idx    word   alt chg  new    exp    err
    vecs[0] = '{0, 3'd2, 8'hA5, 1'b0, -1, 8'h00, 8'hA5, 1'b0};
    vecs[1] = '{0, 3'd0, 8'h3C, 1'b0, -1, 8'h00, 8'h3C, 1'b0};
    vecs[2] = '{0, 3'd3, 8'hC3, 1'b0, -1, 8'h00, 8'hC3, 1'b0};
    vecs[3] = '{0, 3'd6, 8'h00, 1'b0, -1, 8'h00, 8'hFF, 1'b1};
    vecs[4] = '{0, 3'd4, 8'h00, 1'b0, -1, 8'h00, 8'hFF, 1'b1};
    vecs[5] = '{0, 3'd1, 8'h7E, 1'b0, -1, 8'h00, 8'h7E, 1'b0};
    vecs[6] = '{1, 3'd1, 8'h11, 1'b1,  2, 8'h22, 8'h22, 1'b0};
    vecs[7] = '{1, 3'd3, 8'h5A, 1'b0, -1, 8'h00, 8'h5A, 1'b0};
    vecs[8] = '{2, 3'd0, 8'h81, 1'b0, -1, 8'h00, 8'h81, 1'b0};

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) src_val[d][i] = 8'(8'h40 + d * 16 + i);
      tick[d]      = 1'b0;
      req_valid[d] = 1'b1;
      req_index[d] = 3'd1;
      rsp_ready[d] = 1'b0;
    end

    // Reset held with requests pending and Tick toggling
    Reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clock);
      for (int d = 0; d < 3; d++) tick[d] = ~tick[d];
      @(posedge Clock); #1;
      for (int d = 0; d < 3; d++) begin
        check("reset_csn", 32'(csn[d]), 32'hF);
        check("reset_valid", 32'(rsp_valid[d]), 32'd0);
        check("reset_data", 32'(rsp_data[d]), 32'd0);
        check("reset_err", 32'(rsp_err[d]), 32'd0);
      end
    end
    @(negedge Clock);
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0;
      tick[d]      = 1'b1;
    end
    Reset = 1'b1;
    @(posedge Clock); #1;
    for (int d = 0; d < 3; d++) begin
      check("post_reset_req_ready", 32'(req_ready[d]), 32'd1);
      check("post_reset_csn", 32'(csn[d]), 32'hF);
    end

    // Table-driven reads
    for (int v = 0; v < 9; v++) begin
      do_read(vecs[v].d, vecs[v].idx, vecs[v].word, vecs[v].alt, vecs[v].chg,
              vecs[v].new_word, vecs[v].exp_data, vecs[v].exp_err, 0, 3'd0);
    end

    // Backpressure: response held 10 cycles while a second request waits
    do_read(0, 3'd1, 8'h4D, 1'b0, -1, 8'h00, 8'h4D, 1'b0, 10, 3'd2);
    do_read(0, 3'd2, 8'hE7, 1'b0, -1, 8'h00, 8'hE7, 1'b0, 0, 3'd0);

    // Reset during the second cycle of SELECT on the settle-4 instance
    @(negedge Clock);
    src_val[2][3] = 8'h99;
    req_index[2]  = 3'd3;
    req_valid[2]  = 1'b1;
    tick[2]       = 1'b1;
    @(posedge Clock); #1;
    req_valid[2] = 1'b0;
    check("mid_select_csn1", 32'(csn[2]), 32'h7);
    @(posedge Clock); #1;
    check("mid_select_csn2", 32'(csn[2]), 32'h7);
    #3;
    Reset = 1'b0;
    #1;
    check("async_reset_csn", 32'(csn[2]), 32'hF);
    check("async_reset_valid", 32'(rsp_valid[2]), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge Clock); #1;
      check("in_reset_valid", 32'(rsp_valid[2]), 32'd0);
      check("in_reset_csn", 32'(csn[2]), 32'hF);
    end
    @(negedge Clock);
    Reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge Clock); #1;
      check("after_reset_no_rsp", 32'(rsp_valid[2]), 32'd0);
      check("after_reset_csn", 32'(csn[2]), 32'hF);
    end
    check("after_reset_req_ready", 32'(req_ready[2]), 32'd1);
    do_read(2, 3'd3, 8'h66, 1'b0, -1, 8'h00, 8'h66, 1'b0, 0, 3'd0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
